// File: rtl/clk_div_monitor_if.sv
// Bundles the divider-monitor control inputs and measurement/status outputs.
// The master side drives the divider clock and ratio; the slave side is the monitor.
interface clk_div_monitor_if #(
  parameter int MAX_DIV_BITS = 4,
  parameter int ERR_CNT_W    = 8
);
  logic                    i_mon_en;
  logic [MAX_DIV_BITS-1:0] i_div_ratio;
  logic                    i_div_clk;
  logic [MAX_DIV_BITS:0]   o_period;
  logic [MAX_DIV_BITS:0]   o_high_time;
  logic                    o_meas_valid;
  logic                    o_lock;
  logic                    o_ratio_err;
  logic                    o_stuck;
  logic [ERR_CNT_W-1:0]    o_err_cnt;

  modport master (
    output i_mon_en, i_div_ratio, i_div_clk,
    input  o_period, o_high_time, o_meas_valid, o_lock, o_ratio_err, o_stuck, o_err_cnt
  );

  modport slave (
    input  i_mon_en, i_div_ratio, i_div_clk,
    output o_period, o_high_time, o_meas_valid, o_lock, o_ratio_err, o_stuck, o_err_cnt
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in reference-clock cycles and
// reports lock, ratio mismatch and stuck-clock status against the programmed ratio.
module clk_div_monitor #(
  parameter int MAX_DIV_BITS = 4,
  parameter int LOCK_CNT     = 4,
  parameter int ERR_CNT_W    = 8
) (
  input logic               i_ref_clk,
  input logic               i_rst_n,
  clk_div_monitor_if.slave  mon
);
  localparam int CW = MAX_DIV_BITS + 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_CNT);

  typedef enum logic [2:0] {IDLE, BYPASS, SYNC, MEASURE, LOCKED} state_t;

  state_t                  state;
  logic                    d1, d2;
  logic                    rise, fall;
  logic [MAX_DIV_BITS-1:0] r_ratio;
  logic [CW-1:0]           cnt, hi_cnt;
  logic [GW-1:0]           good_cnt, good_inc;
  logic [CW-1:0]           period, high_time;
  logic                    meas_valid, lock, ratio_err, stuck;
  logic [ERR_CNT_W-1:0]    err_cnt, err_inc;
  logic [CW-1:0]           ratio_ext, stuck_lim, half_lo, half_hi;
  logic                    good_period, ratio_chg, new_bypass;

  always_comb begin
    rise        = d1 & ~d2;
    fall        = ~d1 & d2;
    ratio_ext   = {1'b0, r_ratio};
    stuck_lim   = {r_ratio, 1'b0};
    half_lo     = ratio_ext >> 1;
    half_hi     = (ratio_ext + 1'b1) >> 1;
    // hi_cnt < cnt guarantees a non-zero low phase
    good_period = (cnt == ratio_ext) && ((hi_cnt == half_lo) || (hi_cnt == half_hi)) &&
                  (hi_cnt < cnt);
    ratio_chg   = (mon.i_div_ratio != r_ratio);
    new_bypass  = (mon.i_div_ratio <= MAX_DIV_BITS'(1));
    good_inc    = (good_cnt == LOCK_MAX) ? good_cnt : good_cnt + 1'b1;
    err_inc     = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      d1     <= 1'b0;
      d2     <= 1'b0;
      cnt    <= '0;
      hi_cnt <= '0;
    end else begin
      d1 <= mon.i_div_clk;
      d2 <= d1;
      if (rise)
        cnt <= CW'(1);
      else if (!(&cnt))
        cnt <= cnt + 1'b1;
      if (fall)
        hi_cnt <= cnt;
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      r_ratio    <= '0;
      good_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      lock       <= 1'b0;
      ratio_err  <= 1'b0;
      stuck      <= 1'b0;
      err_cnt    <= '0;
    end else begin
      meas_valid <= 1'b0;
      ratio_err  <= 1'b0;
      if (!mon.i_mon_en) begin
        state    <= IDLE;
        lock     <= 1'b0;
        good_cnt <= '0;
      end else if (state == IDLE) begin
        r_ratio  <= mon.i_div_ratio;
        good_cnt <= '0;
        state    <= new_bypass ? BYPASS : SYNC;
        if (new_bypass)
          stuck <= 1'b0;
      end else if (ratio_chg) begin
        // A ratio change takes priority over any coincident rise; that period is dropped
        r_ratio  <= mon.i_div_ratio;
        lock     <= 1'b0;
        good_cnt <= '0;
        stuck    <= 1'b0;
        state    <= new_bypass ? BYPASS : SYNC;
      end else begin
        case (state)
          BYPASS: begin
            lock  <= 1'b0;
            stuck <= 1'b0;
          end
          SYNC: begin
            if (rise) begin
              stuck <= 1'b0;
              state <= MEASURE;
            end
          end
          MEASURE, LOCKED: begin
            if (rise) begin
              meas_valid <= 1'b1;
              period     <= cnt;
              high_time  <= hi_cnt;
              if (good_period) begin
                good_cnt <= good_inc;
                if (good_inc == LOCK_MAX) begin
                  lock  <= 1'b1;
                  state <= LOCKED;
                end
              end else begin
                ratio_err <= 1'b1;
                good_cnt  <= '0;
                lock      <= 1'b0;
                err_cnt   <= err_inc;
                state     <= MEASURE;
              end
            end else if (cnt >= stuck_lim) begin
              stuck    <= 1'b1;
              lock     <= 1'b0;
              good_cnt <= '0;
              err_cnt  <= err_inc;
              state    <= SYNC;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mon.o_period     = period;
  assign mon.o_high_time  = high_time;
  assign mon.o_meas_valid = meas_valid;
  assign mon.o_lock       = lock;
  assign mon.o_ratio_err  = ratio_err;
  assign mon.o_stuck      = stuck;
  assign mon.o_err_cnt    = err_cnt;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock, duty variants, bypass, ratio errors,
// stuck detection, ratio change and mid-lock reset.
module tb_clk_div_monitor;
  logic clk = 1'b0;
  logic rst_n;
  logic div_drv;
  logic bypass_sel;

  int checks = 0;
  int passes = 0;

  int        meas_n;
  int        first_lock;
  int        err_pulses;
  bit        lock_ever;
  logic [4:0] per_h [0:511];
  logic [4:0] hi_h  [0:511];
  logic [7:0] err_h [0:511];

  clk_div_monitor_if #(.MAX_DIV_BITS(4), .ERR_CNT_W(8)) bus ();

  clk_div_monitor #(.MAX_DIV_BITS(4), .LOCK_CNT(4), .ERR_CNT_W(8)) dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .mon       (bus)
  );

  always #5 clk = ~clk;
  assign bus.i_div_clk = bypass_sel ? clk : div_drv;

  task automatic clear_rec();
    meas_n     = 0;
    first_lock = 0;
    err_pulses = 0;
    lock_ever  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.o_meas_valid) begin
      meas_n++;
      if (meas_n < 512) begin
        per_h[meas_n] = bus.o_period;
        hi_h[meas_n]  = bus.o_high_time;
        err_h[meas_n] = bus.o_err_cnt;
      end
      if (bus.o_lock && first_lock == 0) first_lock = meas_n;
    end
    if (bus.o_ratio_err) err_pulses++;
    if (bus.o_lock) lock_ever = 1'b1;
  endtask

  task automatic drive_clk(input int h, input int l);
    div_drv = 1'b1;
    for (int i = 0; i < h; i++) tick();
    div_drv = 1'b0;
    for (int i = 0; i < l; i++) tick();
  endtask

  task automatic do_reset();
    bus.i_mon_en    = 1'b0;
    bus.i_div_ratio = '0;
    div_drv         = 1'b0;
    bypass_sel      = 1'b0;
    rst_n           = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_rec();
  endtask

  task automatic start(input logic [3:0] ratio);
    bus.i_div_ratio = ratio;
    bus.i_mon_en    = 1'b1;
    tick();
    clear_rec();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.o_period, bus.o_high_time, bus.o_meas_valid, bus.o_lock, bus.o_ratio_err,
         bus.o_stuck, bus.o_err_cnt} !== 25'd0)
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%0d l=%0d e=%0d s=%0d c=%0d want all 0",
               bus.o_period, bus.o_high_time, bus.o_meas_valid, bus.o_lock,
               bus.o_ratio_err, bus.o_stuck, bus.o_err_cnt);
    else passes++;
  endtask

  task automatic test_lock4();
    do_reset();
    start(4'd4);
    for (int i = 0; i < 6; i++) drive_clk(2, 2);
    checks++;
    if (meas_n !== 5) $display("FAIL lock4_meas_n: got %0d want 5", meas_n); else passes++;
    checks++;
    if (first_lock !== 4) $display("FAIL lock4_first_lock: got %0d want 4", first_lock); else passes++;
    checks++;
    if (bus.o_period !== 5'd4) $display("FAIL lock4_period: got %0d want 4", bus.o_period); else passes++;
    checks++;
    if (bus.o_high_time !== 5'd2) $display("FAIL lock4_high: got %0d want 2", bus.o_high_time); else passes++;
    checks++;
    if (bus.o_lock !== 1'b1) $display("FAIL lock4_lock: got %0b want 1", bus.o_lock); else passes++;
    checks++;
    if (bus.o_err_cnt !== 8'd0) $display("FAIL lock4_err_cnt: got %0d want 0", bus.o_err_cnt); else passes++;
  endtask

  task automatic test_odd_duty();
    do_reset();
    start(4'd5);
    drive_clk(2, 3);
    drive_clk(2, 3);
    drive_clk(3, 2);
    drive_clk(2, 3);
    drive_clk(3, 2);
    drive_clk(2, 3);
    checks++;
    if (first_lock !== 4) $display("FAIL odd_first_lock: got %0d want 4", first_lock); else passes++;
    checks++;
    if (hi_h[1] !== 5'd2 || per_h[1] !== 5'd5)
      $display("FAIL odd_high2: got p=%0d h=%0d want p=5 h=2", per_h[1], hi_h[1]);
    else passes++;
    checks++;
    if (hi_h[3] !== 5'd3 || per_h[3] !== 5'd5)
      $display("FAIL odd_high3: got p=%0d h=%0d want p=5 h=3", per_h[3], hi_h[3]);
    else passes++;
    checks++;
    if (err_pulses !== 0 || bus.o_err_cnt !== 8'd0)
      $display("FAIL odd_no_err: got pulses=%0d cnt=%0d want 0", err_pulses, bus.o_err_cnt);
    else passes++;
  endtask

  task automatic test_bypass();
    do_reset();
    bypass_sel = 1'b1;
    start(4'd1);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (meas_n !== 0 || lock_ever || bus.o_stuck !== 1'b0)
      $display("FAIL bypass_r1: got meas=%0d lock_ever=%0b stuck=%0b want 0", meas_n, lock_ever, bus.o_stuck);
    else passes++;
    bus.i_div_ratio = 4'd0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (meas_n !== 0 || lock_ever || bus.o_stuck !== 1'b0)
      $display("FAIL bypass_r0: got meas=%0d lock_ever=%0b stuck=%0b want 0", meas_n, lock_ever, bus.o_stuck);
    else passes++;
    checks++;
    if (bus.o_err_cnt !== 8'd0) $display("FAIL bypass_err_cnt: got %0d want 0", bus.o_err_cnt); else passes++;
    bypass_sel = 1'b0;
  endtask

  task automatic test_ratio_err();
    do_reset();
    start(4'd6);
    for (int i = 0; i < 261; i++) drive_clk(2, 2);
    checks++;
    if (err_h[1] !== 8'd1 || err_h[2] !== 8'd2 || err_h[3] !== 8'd3)
      $display("FAIL err_seq: got %0d,%0d,%0d want 1,2,3", err_h[1], err_h[2], err_h[3]);
    else passes++;
    checks++;
    if (err_pulses !== 260) $display("FAIL err_pulses: got %0d want 260", err_pulses); else passes++;
    checks++;
    if (lock_ever) $display("FAIL err_no_lock: got lock_ever=1 want 0"); else passes++;
    checks++;
    if (bus.o_err_cnt !== 8'd255) $display("FAIL err_saturate: got %0d want 255", bus.o_err_cnt); else passes++;
    checks++;
    if (per_h[260] !== 5'd4) $display("FAIL err_period: got %0d want 4", per_h[260]); else passes++;
    bus.i_mon_en = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.o_err_cnt !== 8'd255 || bus.o_lock !== 1'b0)
      $display("FAIL disable_retain: got cnt=%0d lock=%0b want 255,0", bus.o_err_cnt, bus.o_lock);
    else passes++;
  endtask

  task automatic test_stuck();
    do_reset();
    start(4'd3);
    for (int i = 0; i < 5; i++) drive_clk(2, 1);
    checks++;
    if (first_lock !== 4 || bus.o_lock !== 1'b1)
      $display("FAIL stuck_prelock: got first=%0d lock=%0b want 4,1", first_lock, bus.o_lock);
    else passes++;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.o_stuck !== 1'b0 || bus.o_lock !== 1'b1)
      $display("FAIL stuck_early: got stuck=%0b lock=%0b want 0,1", bus.o_stuck, bus.o_lock);
    else passes++;
    tick();
    checks++;
    if (bus.o_stuck !== 1'b1 || bus.o_lock !== 1'b0)
      $display("FAIL stuck_assert: got stuck=%0b lock=%0b want 1,0", bus.o_stuck, bus.o_lock);
    else passes++;
    checks++;
    if (bus.o_err_cnt !== 8'd1) $display("FAIL stuck_err_cnt: got %0d want 1", bus.o_err_cnt); else passes++;
    for (int i = 0; i < 3; i++) tick();
    clear_rec();
    drive_clk(2, 1);
    checks++;
    if (bus.o_stuck !== 1'b0) $display("FAIL stuck_clear: got %0b want 0", bus.o_stuck); else passes++;
    for (int i = 0; i < 4; i++) drive_clk(2, 1);
    checks++;
    if (first_lock !== 4 || bus.o_lock !== 1'b1 || bus.o_err_cnt !== 8'd1)
      $display("FAIL stuck_relock: got first=%0d lock=%0b cnt=%0d want 4,1,1",
               first_lock, bus.o_lock, bus.o_err_cnt);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    start(4'd8);
    for (int i = 0; i < 5; i++) drive_clk(4, 4);
    checks++;
    if (bus.o_lock !== 1'b1 || first_lock !== 4)
      $display("FAIL r8_lock: got lock=%0b first=%0d want 1,4", bus.o_lock, first_lock);
    else passes++;
    bus.i_div_ratio = 4'd2;
    tick();
    checks++;
    if (bus.o_lock !== 1'b0 || bus.o_err_cnt !== 8'd0 || bus.o_ratio_err !== 1'b0)
      $display("FAIL chg_unlock: got lock=%0b cnt=%0d err=%0b want 0,0,0",
               bus.o_lock, bus.o_err_cnt, bus.o_ratio_err);
    else passes++;
    clear_rec();
    for (int i = 0; i < 5; i++) drive_clk(1, 1);
    checks++;
    if (bus.o_lock !== 1'b1 || first_lock !== 4 || bus.o_period !== 5'd2 || bus.o_high_time !== 5'd1)
      $display("FAIL r2_relock: got lock=%0b first=%0d p=%0d h=%0d want 1,4,2,1",
               bus.o_lock, first_lock, bus.o_period, bus.o_high_time);
    else passes++;
    checks++;
    if (err_pulses !== 0 || bus.o_err_cnt !== 8'd0)
      $display("FAIL r2_no_err: got pulses=%0d cnt=%0d want 0", err_pulses, bus.o_err_cnt);
    else passes++;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.o_period, bus.o_high_time, bus.o_meas_valid, bus.o_lock, bus.o_ratio_err,
         bus.o_stuck, bus.o_err_cnt} !== 25'd0)
      $display("FAIL midlock_reset: got p=%0d h=%0d v=%0d l=%0d e=%0d s=%0d c=%0d want all 0",
               bus.o_period, bus.o_high_time, bus.o_meas_valid, bus.o_lock,
               bus.o_ratio_err, bus.o_stuck, bus.o_err_cnt);
    else passes++;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    div_drv         = 1'b0;
    bypass_sel      = 1'b0;
    bus.i_mon_en    = 1'b0;
    bus.i_div_ratio = '0;
    clear_rec();
    test_reset();
    test_lock4();
    test_odd_duty();
    test_bypass();
    test_ratio_err();
    test_stuck();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
